// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state type and the
// default operand width used by the HI/LO unit and the hazard unit.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } mult_state_t;

endpackage : mult_pkg

// File: rtl/mult_seq_if.sv
// Request/response bundle between the issuing pipeline (master) and mult_seq (slave).
interface mult_seq_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) ();

  // Handshake: start is sampled only while busy=0 and abort=0 (a, b and
  // signed_op are captured on that same edge); busy stays high until the
  // result edge; done pulses for one cycle and z is valid from then on.
  // abort kills an operation in flight and drops a same-cycle start.
  logic                   start;
  logic                   signed_op;
  logic                   abort;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     z;
  mult_state_t            state;

  modport master (
    output start, signed_op, abort, a, b,
    input  busy, done, z, state
  );

  modport slave (
    input  start, signed_op, abort, a, b,
    output busy, done, z, state
  );

endinterface : mult_seq_if

// File: rtl/mult_abs.sv
// Conditional two's-complement negate: y = neg ? -x : x.
module mult_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule : mult_abs

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier (MULT/MULTU), one partial product per cycle.
// Optional `MULT_SEQ_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  mult_seq_if.slave  bus
);

  mult_state_t          state;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   z;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;

  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mag_b_next;
  logic                 last_step;
  logic [2*WIDTH-1:0]   acc_aligned;
  logic [2*WIDTH-1:0]   z_fixed;

  mult_abs #(.W(WIDTH)) u_abs_a (
    .x   (bus.a),
    .neg (bus.signed_op & bus.a[WIDTH-1]),
    .y   (abs_a)
  );

  mult_abs #(.W(WIDTH)) u_abs_b (
    .x   (bus.b),
    .neg (bus.signed_op & bus.b[WIDTH-1]),
    .y   (abs_b)
  );

  mult_abs #(.W(2*WIDTH)) u_fix (
    .x   (acc_aligned),
    .neg (neg),
    .y   (z_fixed)
  );

  // Carry out of the upper-half add becomes the new MSB after the shift.
  assign sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mag_b[0] ? mag_a : '0)};
  assign acc_next   = {sum, acc[WIDTH-1:1]};
  assign mag_b_next = mag_b >> 1;

`ifdef MULT_SEQ_EARLY_EXIT_EN
  logic [CNT_W-1:0] shamt;
  // After cnt steps the product sits WIDTH-cnt bits too high in acc.
  assign shamt       = CNT_W'(WIDTH) - cnt;
  assign last_step   = (mag_b_next == '0) || (cnt == CNT_W'(WIDTH - 1));
  assign acc_aligned = acc >> shamt;
`else
  assign last_step   = (cnt == CNT_W'(WIDTH - 1));
  assign acc_aligned = acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      mag_a <= '0;
      mag_b <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            mag_a <= abs_a;
            mag_b <= abs_b;
            neg   <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (bus.abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc   <= acc_next;
            mag_b <= mag_b_next;
            cnt   <= cnt + 1'b1;
            if (last_step) state <= SIGN;
          end
        end
        SIGN: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!bus.abort) begin
            z    <= z_fixed;
            done <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.z     = z;
  assign bus.state = state;

endmodule : mult_seq

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq at WIDTH=32: directed cases, handshake,
// abort/reset, and random operands against an arithmetic reference model.
module tb_mult_seq;
  import mult_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst_n;

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                              input bit s);
    longint sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      return 64'(sa * sb);
    end
    ua = {32'd0, ra};
    ub = {32'd0, rb};
    return 64'(ua * ub);
  endfunction

  function automatic int ref_latency(input logic [W-1:0] rb, input bit s);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    longint mb;
    int hi;
    mb = s ? longint'($signed(rb)) : longint'({32'd0, rb});
    if (mb < 0) mb = -mb;
    hi = -1;
    for (int i = 0; i < W; i++) if (mb[i]) hi = i;
    return (hi < 0) ? 2 : hi + 2;
`else
    return W + 1;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.abort     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts edges after the start edge until done is seen; -1 on timeout.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit s,
                        input string tag, input bit verbose_checks);
    int edges;
    logic [2*W-1:0] e;
    exp_q.push_back(ref_prod(ta, tb, s));
    @(negedge clk);
    bus.a         = ta;
    bus.b         = tb;
    bus.signed_op = s;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (verbose_checks) check({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
    wait_done(edges);
    check({tag, "_latency"}, 64'(edges), 64'(ref_latency(tb, s)));
    if (verbose_checks) check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    e = exp_q.pop_front();
    check({tag, "_z"}, bus.z, e);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int edges;
    int dones;
    int first_done;
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] prev_z;
    bit rs;

    do_reset();
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_done",  64'(bus.done), 64'd0);
    check("rst_z",     bus.z, 64'd0);
    check("rst_state", 64'(bus.state), 64'(IDLE));

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax", 1'b1);
    check("umax_const", bus.z, 64'hFFFF_FFFE_0000_0001);
    run_op(32'hFFFF_FFF9, 32'd6, 1'b1, "smix", 1'b1);
    check("smix_const", bus.z, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op(32'hFFFF_FFF9, 32'd6, 1'b0, "umix", 1'b0);
    check("umix_const", bus.z, 64'h0000_0005_FFFF_FFD6);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "mostneg", 1'b1);
    check("mostneg_const", bus.z, 64'h4000_0000_0000_0000);
    run_op(32'h1234_5678, 32'd0, 1'b0, "bzero", 1'b0);
    run_op(32'd5, 32'd3, 1'b0, "b3", 1'b0);
    run_op(32'hDEAD_BEEF, 32'h8000_0000, 1'b0, "bmsb", 1'b0);
    run_op(32'd7, 32'hFFFF_FFFF, 1'b1, "sneg1", 1'b0);

    // start pulses during CALC are ignored
    exp_q.push_back(ref_prod(32'h0001_E240, 32'h9ABC_DEF1, 1'b0));
    @(negedge clk);
    bus.a = 32'h0001_E240; bus.b = 32'h9ABC_DEF1; bus.signed_op = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    dones      = 0;
    first_done = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      bus.start = (c == 5 || c == 10);
      if (c == 5 || c == 10) begin
        bus.a = $urandom; bus.b = $urandom; bus.signed_op = 1'b1;
      end
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        if (first_done < 0) first_done = c;
      end
    end
    bus.start = 1'b0;
    check("ignore_dones", 64'(dones), 64'd1);
    check("ignore_latency", 64'(first_done), 64'(ref_latency(32'h9ABC_DEF1, 1'b0)));
    check("ignore_z", bus.z, exp_q.pop_front());

    // start held through done: back-to-back acceptance
    @(negedge clk);
    bus.a = 32'hCAFE_0001; bus.b = 32'h0000_BEEF; bus.signed_op = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(edges);
    check("b2b_first_lat", 64'(edges), 64'(ref_latency(32'h0000_BEEF, 1'b1)));
    check("b2b_first_z", bus.z, ref_prod(32'hCAFE_0001, 32'h0000_BEEF, 1'b1));
    bus.a = 32'h7FFF_FFFF; bus.b = 32'hF000_0003; bus.signed_op = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_no_gap", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    wait_done(edges);
    check("b2b_second_lat", 64'(edges), 64'(ref_latency(32'hF000_0003, 1'b1)));
    check("b2b_second_z", bus.z, ref_prod(32'h7FFF_FFFF, 32'hF000_0003, 1'b1));

    // abort at CALC step 17
    prev_z = bus.z;
    @(negedge clk);
    bus.a = 32'h1357_9BDF; bus.b = 32'hFFFF_FFFF; bus.signed_op = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_state", 64'(bus.state), 64'(IDLE));
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_z_kept", bus.z, prev_z);

    // abort in IDLE beats start
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    check("idle_abort_busy", 64'(bus.busy), 64'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    bus.a = 32'd1000; bus.b = 32'hFFFF_FFF0; bus.signed_op = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_z", bus.z, 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_state", 64'(bus.state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // random operands, biased towards corner values
    for (int n = 0; n < 1500; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: ra = 32'h8000_0000;
        1: rb = 32'h8000_0000;
        2: rb = 32'(rb >> $urandom_range(0, 31));
        3: ra = 32'hFFFF_FFFF;
        4: rb = 32'd0;
        default: ;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, "rand", 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mult_seq
